// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//
// Four-way round-robin arbiter that picks one requester's data word and
// registers it into a single output holding slot. When the slot is empty,
// or is being consumed this cycle, a new word can be loaded.
//
// Ports:
//   clk         - single clock, state updates on the rising edge
//   rst         - asynchronous active-high reset
//   req[3:0]    - request per requester; bit i means din_i holds valid data
//   din0..din3  - requester data channels (WIDTH bits each)
//   gnt[3:0]    - combinational one-hot grant; din_i is captured on this edge
//   sel[1:0]    - registered index of the requester whose word sits in dout
//   dout        - registered muxed data
//   dout_valid  - dout holds an unconsumed word
//   dout_ready  - downstream accepts dout this cycle when dout_valid is high
module mux_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       lg_q, lg_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic             load_en;
  logic             grant;
  logic [1:0]       win;
  logic [1:0]       cand;
  logic [3:0]       gnt_c;
  logic [WIDTH-1:0] win_data;

  // Round-robin search starting just after the last granted index and
  // ending on the last granted index itself. Gating with rst keeps the
  // grant low during reset even though the state decodes as IDLE.
  always_comb begin
    load_en = (state_q == IDLE) || dout_ready;
    grant   = 1'b0;
    win     = lg_q;
    cand    = lg_q;
    gnt_c   = 4'b0000;
    if (load_en && !rst) begin
      for (int k = 1; k <= 4; k++) begin
        cand = lg_q + 2'(k);
        if (!grant && req[cand]) begin
          grant = 1'b1;
          win   = cand;
        end
      end
    end
    if (grant) begin
      gnt_c[win] = 1'b1;
    end
  end

  // Data path mux: only feeds the dout register, never any control output.
  always_comb begin
    win_data = din0;
    case (win)
      2'd0:    win_data = din0;
      2'd1:    win_data = din1;
      2'd2:    win_data = din2;
      default: win_data = din3;
    endcase
  end

  // Next-state: a grant loads the slot (also covering consume-and-reload);
  // a consume without a new grant empties it; otherwise everything holds.
  always_comb begin
    state_d = state_q;
    lg_d    = lg_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    if (grant) begin
      state_d = FULL;
      lg_d    = win;
      sel_d   = win;
      dout_d  = win_data;
    end else if (state_q == FULL && dout_ready) begin
      state_d = IDLE;
    end
  end

  // lg resets to 3 so requester 0 is searched first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lg_q    <= 2'b11;
      sel_q   <= 2'b00;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      lg_q    <= lg_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
    end
  end

  assign gnt        = gnt_c;
  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//
// Self-checking bench for mux_rr_arbiter (WIDTH=4). A vector table walks
// through the directed scenarios, a hand-written sequence covers the
// asynchronous reset, and a random phase compares against a reference
// model with a scoreboard queue of granted words.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din0, din1, din2, din3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic [3:0] req;
    logic       ready;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] exp_gnt;
    logic       exp_valid;
    logic [3:0] exp_dout;
    logic [1:0] exp_sel;
  } vec_t;

  typedef struct {
    logic [1:0] idx;
    logic [3:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];

  mux_rr_arbiter #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input int actual, input int expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic [3:0] r, input logic rdy,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d,
                        input logic [3:0] eg, input logic ev,
                        input logic [3:0] ed, input logic [1:0] es);
    vec_t v;
    v.req = r; v.ready = rdy;
    v.d0 = a; v.d1 = b; v.d2 = c; v.d3 = d;
    v.exp_gnt = eg; v.exp_valid = ev; v.exp_dout = ed; v.exp_sel = es;
    vecs.push_back(v);
  endtask

  // Drives one table row just after a rising edge, checks the
  // combinational grant, then checks the registered outputs after the edge.
  task automatic applyStimulus(input int idx, input vec_t v);
    req        = v.req;
    dout_ready = v.ready;
    din0 = v.d0; din1 = v.d1; din2 = v.d2; din3 = v.d3;
    #1;
    checkOutput($sformatf("row%0d gnt", idx), int'(gnt), int'(v.exp_gnt));
    @(posedge clk);
    #1;
    checkOutput($sformatf("row%0d dout_valid", idx), int'(dout_valid), int'(v.exp_valid));
    checkOutput($sformatf("row%0d dout", idx), int'(dout), int'(v.exp_dout));
    checkOutput($sformatf("row%0d sel", idx), int'(sel), int'(v.exp_sel));
  endtask

  // Reference arbitration: first requester after the last grant, wrapping.
  function automatic logic [3:0] model_gnt(input logic [3:0] r, input int lg, input bit en);
    for (int off = 1; off <= 4; off++) begin
      int i;
      i = (lg + off) % 4;
      if (en && r[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  task automatic pulseReset();
    rst = 1'b1;
    req = 4'b0000;
    dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         m_lg;
    bit         m_full;
    bit         consumed;
    logic [3:0] exp_g;
    logic [3:0] held;
    logic [3:0] dins [4];
    sb_t        e;
    int         w;

    rst = 1'b1;
    req = 4'b1111;
    dout_ready = 1'b1;
    din0 = 4'd1; din1 = 4'd2; din2 = 4'd3; din3 = 4'd4;

    // Reset state, with all requests high to show gnt is blocked.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset gnt", int'(gnt), 0);
    checkOutput("reset dout_valid", int'(dout_valid), 0);
    checkOutput("reset dout", int'(dout), 0);
    checkOutput("reset sel", int'(sel), 0);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Rotation with all requesters and downstream always ready.
    addVec(4'b1111, 1, 1, 2, 3, 4, 4'b0001, 1, 1, 0);
    addVec(4'b1111, 1, 1, 2, 3, 4, 4'b0010, 1, 2, 1);
    addVec(4'b1111, 1, 1, 2, 3, 4, 4'b0100, 1, 3, 2);
    addVec(4'b1111, 1, 1, 2, 3, 4, 4'b1000, 1, 4, 3);
    addVec(4'b1111, 1, 1, 2, 3, 4, 4'b0001, 1, 1, 0);
    // Consume with no requests: empties, dout/sel hold.
    addVec(4'b0000, 1, 1, 2, 3, 4, 4'b0000, 0, 1, 0);
    // Single grant to 2 while downstream stalls; other requests ignored.
    addVec(4'b0100, 0, 1, 2, 14, 4, 4'b0100, 1, 14, 2);
    addVec(4'b1010, 0, 1, 2, 14, 4, 4'b0000, 1, 14, 2);
    addVec(4'b1010, 0, 1, 2, 14, 4, 4'b0000, 1, 14, 2);
    addVec(4'b1010, 0, 1, 2, 14, 4, 4'b0000, 1, 14, 2);
    addVec(4'b0000, 1, 1, 2, 14, 4, 4'b0000, 0, 14, 2);
    // IDLE ignores dout_ready; after lg=2 the search starts at 3.
    addVec(4'b1010, 0, 1, 2, 3, 4, 4'b1000, 1, 4, 3);
    // Wrap from lg=3 to requester 0, then on to 3.
    addVec(4'b1001, 1, 1, 2, 3, 4, 4'b0001, 1, 1, 0);
    addVec(4'b1001, 1, 1, 2, 3, 4, 4'b1000, 1, 4, 3);
    // Single persistent requester wins every opportunity.
    addVec(4'b1000, 1, 1, 2, 3, 4, 4'b1000, 1, 4, 3);
    addVec(4'b1000, 1, 1, 2, 3, 13, 4'b1000, 1, 13, 3);

    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Asynchronous reset in the middle of a cycle while holding 4'b1101.
    #2;
    req = 4'b1111;
    rst = 1'b1;
    #1;
    checkOutput("async rst dout_valid", int'(dout_valid), 0);
    checkOutput("async rst dout", int'(dout), 0);
    checkOutput("async rst sel", int'(sel), 0);
    checkOutput("async rst gnt", int'(gnt), 0);
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post rst dout_valid", int'(dout_valid), 0);
    begin
      vec_t v;
      v.req = 4'b1111; v.ready = 1'b1;
      v.d0 = 4'd1; v.d1 = 4'd2; v.d2 = 4'd3; v.d3 = 4'd4;
      v.exp_gnt = 4'b0001; v.exp_valid = 1'b1; v.exp_dout = 4'd1; v.exp_sel = 2'd0;
      applyStimulus(99, v);
    end

    // Random phase against the reference model and scoreboard.
    pulseReset();
    m_lg   = 3;
    m_full = 1'b0;
    held   = 4'b0000;
    sb_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      req        = held | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      dout_ready = ($urandom_range(0, 3) != 0);
      din0 = 4'($urandom_range(0, 15));
      din1 = 4'($urandom_range(0, 15));
      din2 = 4'($urandom_range(0, 15));
      din3 = 4'($urandom_range(0, 15));
      dins[0] = din0; dins[1] = din1; dins[2] = din2; dins[3] = din3;
      #1;
      exp_g = model_gnt(req, m_lg, !m_full || dout_ready);
      checkOutput("rand gnt", int'(gnt), int'(exp_g));
      checkOutput("rand gnt onehot0", int'($onehot0(gnt)), 1);

      consumed = m_full && dout_ready;
      if (consumed && sb_q.size() > 0) void'(sb_q.pop_front());
      if (exp_g != 4'b0000) begin
        w = $clog2(int'(exp_g));
        e.idx  = 2'(w);
        e.data = dins[w];
        sb_q.push_back(e);
        m_full = 1'b1;
        m_lg   = w;
      end else if (consumed) begin
        m_full = 1'b0;
      end
      held = req & ~exp_g;

      @(posedge clk);
      #1;
      checkOutput("rand dout_valid", int'(dout_valid), int'(m_full));
      if (m_full) begin
        checkOutput("rand sb depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          checkOutput("rand dout", int'(dout), int'(sb_q[0].data));
          checkOutput("rand sel", int'(sel), int'(sb_q[0].idx));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, data width of each requester channel and of dout.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req  input  4  request per requester; bit i asserted means requester i has valid data on din_i.
REQ-005 Port: din0, din1, din2, din3  input  WIDTH each  requester data channels 0 to 3.
REQ-006 Port: gnt  output  4  one-hot, combinational; bit i high for one cycle means din_i is captured on this edge.
REQ-007 Port: sel  output  2  registered index of the requester whose data is held in dout.
REQ-008 Port: dout  output  WIDTH  registered muxed data.
REQ-009 Port: dout_valid  output  1  dout holds an unconsumed word.
REQ-010 Port: dout_ready  input  1  downstream accepts dout this cycle when dout_valid is high.

Function
REQ-011 Two states: IDLE (dout_valid=0) and FULL (dout_valid=1); dout_valid is a direct decode of the state.
REQ-012 load_en is (state==IDLE) or (state==FULL and dout_ready==1).
REQ-013 When load_en=1 and req!=0, exactly one gnt bit is high; otherwise gnt=4'b0000.
REQ-014 Arbitration is round-robin against a 2-bit last-grant pointer lg.
REQ-015 Search order is lg+1, lg+2, lg+3, lg, all modulo 4; the first index with req set wins.
REQ-016 On a grant to index w: dout<=din_w, sel<=w, lg<=w, next state FULL, all on the same edge.
REQ-017 Latency is one cycle: data granted in cycle N appears on dout with dout_valid=1 in cycle N+1.
REQ-018 In FULL with dout_ready=0: dout, sel, lg and state hold; gnt=0; requests are ignored without loss, and requesters keep req high until granted.
REQ-019 In FULL with dout_ready=1 and req!=0: consume and reload on the same edge, state stays FULL, giving back-to-back throughput of one word per cycle.
REQ-020 In FULL with dout_ready=1 and req=0: next state IDLE; dout and sel hold their last values.
REQ-021 In IDLE with req=0: no change.
REQ-022 dout_ready is ignored while in IDLE.
REQ-023 When lg=3 the search wraps to index 0 first.
REQ-024 A single persistent requester is granted every load opportunity.
REQ-025 With all four requesters persistently high, grants rotate 0,1,2,3,0,…; no requester waits more than 3 grants.
REQ-026 gnt depends only on the current req, state, dout_ready and lg; there is no combinational path from din to any control output.

Reset
REQ-027 While rst=1, the following values hold immediately, independent of clk: state=IDLE, dout_valid=0, dout=0, sel=2'b00, lg=2'b11 (so requester 0 has first priority).
REQ-028 While rst=1, gnt=4'b0000 regardless of req.
REQ-029 If rst asserts mid-operation, any word held in dout is discarded.
REQ-030 The first grant after rst deasserts follows REQ-015 with lg=3.

Verification
REQ-031 Scenario: reset, then req=4'b1111, din0..3=1,2,3,4, dout_ready=1 held.
  - Required: gnt sequence 0001, 0010, 0100, 1000, 0001.
  - Required: dout sequence 1,2,3,4,1, each appearing one cycle after its grant.
  - Required: dout_valid stays 1.
REQ-032 Scenario: req=4'b0100, din2=4'b1110, dout_ready=0 for 3 cycles, then 1.
  - Required: exactly one gnt=0100.
  - Required: dout=14, sel=2, dout_valid=1 held for 3 cycles.
  - Required: consume on the ready edge, then state IDLE.
REQ-033 Scenario: after a grant to requester 3, assert req=4'b1001.
  - Required: next grant goes to 0 (wrap), then to 3.
REQ-034 Scenario: FULL with dout_ready=1 and req=0.
  - Required: dout_valid falls next cycle; dout/sel unchanged; gnt=0.
REQ-035 Scenario: rst pulsed asynchronously while FULL with dout=4'b1101.
  - Required: dout_valid=0, dout=0, sel=0 before the next clk edge.
  - Required: the next grant with req=4'b1111 goes to requester 0.
REQ-036 Scenario: random req, din, dout_ready for at least 2000 cycles against a reference model.
  - Required: every granted word appears exactly once on dout in grant order.
  - Required: gnt is one-hot or zero at all times.
